// File: rtl/serial_add3bit_if.sv
// Operand/result handshake bundle for serial_add3bit.
// master: operand source and result sink; slave: the adder.
interface serial_add3bit_if #(
   parameter int WIDTH = 3
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH:0]   out;
   logic             busy;

   modport master (
      output in_valid, A, B, out_ready,
      input  in_ready, out_valid, out, busy
   );

   modport slave (
      input  in_valid, A, B, out_ready,
      output in_ready, out_valid, out, busy
   );
endinterface

// File: rtl/serial_add3bit.sv
// Bit-serial unsigned adder: one full-adder evaluation per clock, LSB first.
// Result {carry-out, sum} is returned through a valid/ready handshake.
module serial_add3bit #(
   parameter int WIDTH = 3
) (
   input  logic            clk,
   input  logic            rst,
   serial_add3bit_if.slave bus
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_sh, b_sh, s_sh, sum_nxt;
   logic             c, c_nxt, s_bit, last_bit;
   logic [CW-1:0]    cnt;
   logic [WIDTH:0]   res;

   // Full-adder cell on the current LSBs and the sum word after inserting the new bit.
   // The final word is built from sum_nxt so the result register can load it on the last edge.
   always_comb begin
      s_bit    = a_sh[0] ^ b_sh[0] ^ c;
      c_nxt    = (a_sh[0] & b_sh[0]) | (c & (a_sh[0] ^ b_sh[0]));
      sum_nxt  = (s_sh >> 1) | (WIDTH'(s_bit) << (WIDTH - 1));
      last_bit = (cnt == CW'(WIDTH - 1));
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state and handshake outputs.
   always_comb begin
      state_nxt     = state;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.busy      = 1'b0;
      case (state)
         IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) state_nxt = BUSY;
         end
         BUSY: begin
            bus.busy = 1'b1;
            if (last_bit) state_nxt = DONE;
         end
         DONE: begin
            bus.busy      = 1'b1;
            bus.out_valid = 1'b1;
            if (bus.out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Operand capture, serial shift/carry datapath and result register.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_sh <= '0;
         b_sh <= '0;
         s_sh <= '0;
         c    <= 1'b0;
         cnt  <= '0;
         res  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  a_sh <= bus.A;
                  b_sh <= bus.B;
                  s_sh <= '0;
                  c    <= 1'b0;
                  cnt  <= '0;
               end
            end
            BUSY: begin
               a_sh <= a_sh >> 1;
               b_sh <= b_sh >> 1;
               s_sh <= sum_nxt;
               c    <= c_nxt;
               cnt  <= cnt + CW'(1);
               if (last_bit) res <= {c_nxt, sum_nxt};
            end
            default: ;
         endcase
      end
   end

   assign bus.out = res;
endmodule

// File: tb/tb_serial_add3bit.sv
// Scoreboard bench for serial_add3bit: driver pushes A+B, monitor pops on each transfer.
module tb_serial_add3bit;
   localparam int W = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int unsigned cyc = 0;

   serial_add3bit_if #(.WIDTH(W)) bus ();

   serial_add3bit #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;
   int exp_q[$];
   int unsigned acc_q[$];
   int n_acc = 0, n_xfer = 0, n_abort = 0;
   int or_mode = 0;   // 0: always ready, 1: stalled, 2: random

   task automatic check(input string name, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // out_ready driven away from both the active edge and the monitor's sampling edge
   always @(posedge clk) begin
      #2;
      case (or_mode)
         0:       bus.out_ready = 1'b1;
         1:       bus.out_ready = 1'b0;
         default: bus.out_ready = ($urandom_range(0, 3) != 0);
      endcase
   end

   // Monitor: protocol checks, latency, stability and scoreboard compare
   logic prev_ov = 1'b0, prev_xfer = 1'b0;
   logic [W:0] prev_out = '0;
   always @(negedge clk) begin
      if (rst) begin
         prev_ov   = 1'b0;
         prev_xfer = 1'b0;
      end else begin
         logic xfer;
         check("busy_eq_not_ready", int'(bus.busy), int'(!bus.in_ready));
         if (prev_xfer) begin
            check("ready_after_xfer", int'(bus.in_ready), 1);
            check("valid_drop_after_xfer", int'(bus.out_valid), 0);
         end
         if (bus.out_valid && !prev_ov) begin
            if (acc_q.size() == 0) check("unexpected_valid", 1, 0);
            else check("latency", int'(cyc - acc_q.pop_front()), W);
         end
         if (bus.out_valid && prev_ov)
            check("out_stable", int'(bus.out), int'(prev_out));
         xfer = bus.out_valid && bus.out_ready;
         if (xfer) begin
            n_xfer++;
            if (exp_q.size() == 0) check("result_without_op", 1, 0);
            else check("sum", int'(bus.out), exp_q.pop_front());
         end
         prev_ov   = bus.out_valid;
         prev_xfer = xfer;
         prev_out  = bus.out;
      end
   end

   task automatic send(input int a, input int b);
      int unsigned n = 0;
      @(negedge clk);
      while (!bus.in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!bus.in_ready) begin
         check("accept_timeout", 0, 1);
         return;
      end
      bus.in_valid = 1'b1;
      bus.A = W'(a);
      bus.B = W'(b);
      @(posedge clk);
      #1;
      exp_q.push_back((a % (1 << W)) + (b % (1 << W)));
      acc_q.push_back(cyc);
      n_acc++;
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int unsigned n = 0;
      @(negedge clk);
      while ((exp_q.size() != 0 || !bus.in_ready) && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("drain_timeout", int'(exp_q.size() == 0 && bus.in_ready), 1);
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.A = '0;
      bus.B = '0;
      bus.out_ready = 1'b1;

      // reset held for 2 cycles
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_in_ready", int'(bus.in_ready), 1);
      check("rst_out_valid", int'(bus.out_valid), 0);
      check("rst_out", int'(bus.out), 0);
      check("rst_busy", int'(bus.busy), 0);

      // directed sums
      send(3, 4);
      send(7, 7);
      send(0, 0);
      send(7, 1);
      drain();

      // backpressure with ignored in_valid pulses
      or_mode = 1;
      @(posedge clk);
      send(5, 6);
      begin
         int unsigned n = 0;
         while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            n++;
         end
         check("stall_valid_seen", int'(bus.out_valid), 1);
      end
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("stall_in_ready", int'(bus.in_ready), 0);
         check("stall_out", int'(bus.out), 11);
         bus.in_valid = i[0];
         bus.A = W'($urandom);
         bus.B = W'($urandom);
      end
      begin
         int x0;
         @(negedge clk);
         bus.in_valid = 1'b0;
         or_mode = 0;
         x0 = n_xfer;
         repeat (3) @(negedge clk);
         check("stall_one_xfer", n_xfer - x0, 1);
         check("stall_back_idle", int'(bus.in_ready), 1);
      end

      // reset on the 2nd BUSY cycle aborts the operation
      send(6, 3);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
      acc_q.delete();
      n_abort++;
      @(negedge clk);
      check("abort_in_ready", int'(bus.in_ready), 1);
      check("abort_out_valid", int'(bus.out_valid), 0);
      check("abort_out", int'(bus.out), 0);
      check("abort_busy", int'(bus.busy), 0);
      send(1, 2);
      drain();

      // exhaustive pairs then random pairs, random stalls and gaps
      or_mode = 2;
      for (int a = 0; a < 8; a++)
         for (int b = 0; b < 8; b++) begin
            send(a, b);
            repeat ($urandom_range(0, 2)) @(negedge clk);
         end
      for (int i = 0; i < 40; i++) begin
         send(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      drain();
      check("result_count", n_xfer, n_acc - n_abort);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
